// File: rtl/threshold2_histogram.sv
// Frame histogram: clears, accumulates pixel counts per gray level, then streams all bins out.
// Optional build macro THRESHOLD2_HIST_SAT_EN makes bin counts saturate instead of wrapping.
module threshold2_histogram #(
    parameter int BIN_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [BIN_W-1:0] pix_tdata,
    input  logic             pix_tvalid,
    output logic             pix_tready,
    input  logic             pix_tlast,
    output logic [BIN_W-1:0] hist_bin,
    output logic [CNT_W-1:0] hist_cnt,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic             hist_last
);
    // state | meaning
    // CLEAR | zero every bin, one per cycle, after reset
    // ACCUM | accept pixels, read-modify-write the addressed bin
    // DRAIN | let the last increment commit before reading bins out
    // DUMP  | stream bins 0..max, zeroing each as its beat transfers

    localparam int NBINS = 1 << BIN_W;
    localparam logic [BIN_W-1:0] BIN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;
    state_t state;

    logic [CNT_W-1:0] mem [NBINS];
    logic [CNT_W-1:0] rdata;
    logic [CNT_W-1:0] wdata;
    logic [BIN_W-1:0] waddr;
    logic [BIN_W-1:0] raddr;
    logic             we;

    logic [BIN_W-1:0] clr_ptr;
    logic             s1_valid;
    logic [BIN_W-1:0] s1_bin;
    logic             fwd_hit;
    logic [CNT_W-1:0] fwd_data;
    logic             rd_first;
    logic             rd_valid;
    logic [BIN_W-1:0] rd_bin;

    logic             acc_xfer;
    logic             out_xfer;
    logic             out_free;
    logic             rd_adv;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] incr;

    always_ff @(posedge ap_clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    assign acc_xfer = pix_tvalid && pix_tready;
    assign out_xfer = hist_valid && hist_ready;
    assign out_free = !hist_valid || hist_ready;
    assign rd_adv   = (state == DUMP) && rd_valid && out_free;

    // The RAM read of a pixel misses a write to the same bin landing on the same edge.
    assign base = fwd_hit ? fwd_data : rdata;

`ifdef THRESHOLD2_HIST_SAT_EN
    assign incr = (base == CNT_MAX) ? base : base + 1'b1;
`else
    assign incr = base + 1'b1;
`endif

    // While the output is stalled the pending bin is re-read so rdata stays put.
    always_comb begin
        raddr = pix_tdata;
        if (state == DUMP) begin
            if (rd_first)    raddr = '0;
            else if (rd_adv) raddr = rd_bin + 1'b1;
            else             raddr = rd_bin;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = s1_bin;
        wdata = incr;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_ptr;
            wdata = '0;
        end else if (s1_valid) begin
            we = 1'b1;
        end else if ((state == DUMP) && out_xfer) begin
            we    = 1'b1;
            waddr = hist_bin;
            wdata = '0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            pix_tready <= 1'b0;
            hist_valid <= 1'b0;
            hist_last  <= 1'b0;
            hist_bin   <= '0;
            hist_cnt   <= '0;
            s1_valid   <= 1'b0;
            s1_bin     <= '0;
            fwd_hit    <= 1'b0;
            fwd_data   <= '0;
            rd_first   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_bin     <= '0;
        end else begin
            s1_valid <= acc_xfer;
            s1_bin   <= pix_tdata;
            fwd_hit  <= acc_xfer && s1_valid && (s1_bin == pix_tdata);
            fwd_data <= incr;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == BIN_MAX) begin
                        state      <= ACCUM;
                        pix_tready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (acc_xfer && pix_tlast) begin
                        state      <= DRAIN;
                        pix_tready <= 1'b0;
                    end
                end
                DRAIN: begin
                    state    <= DUMP;
                    rd_first <= 1'b1;
                    rd_valid <= 1'b0;
                    rd_bin   <= '0;
                end
                DUMP: begin
                    if (rd_first) begin
                        rd_first <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_bin   <= '0;
                    end else if (rd_adv) begin
                        hist_valid <= 1'b1;
                        hist_bin   <= rd_bin;
                        hist_cnt   <= rdata;
                        hist_last  <= (rd_bin == BIN_MAX);
                        rd_valid   <= (rd_bin != BIN_MAX);
                        rd_bin     <= rd_bin + 1'b1;
                    end else if (out_xfer) begin
                        hist_valid <= 1'b0;
                    end
                    if (out_xfer && hist_last) begin
                        state      <= ACCUM;
                        pix_tready <= 1'b1;
                        hist_valid <= 1'b0;
                        hist_last  <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_threshold2_histogram.sv
// Directed bench for threshold2_histogram: frames with hand-computed bin counts, dump handshake, reset.
// A second narrow-count instance exercises the wrap/saturate behaviour of THRESHOLD2_HIST_SAT_EN.
module tb_threshold2_histogram;
    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic        ap_rst;
    logic [7:0]  pix_tdata;
    logic        pix_tvalid, pix_tready, pix_tlast;
    logic [7:0]  hist_bin;
    logic [19:0] hist_cnt;
    logic        hist_valid, hist_ready, hist_last;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_bin;
    logic [3:0]  s_cnt;
    logic        s_valid, s_ready, s_last;

    int total = 0;
    int bad   = 0;
    logic [19:0] got   [256];
    logic [19:0] exp_h [256];

    threshold2_histogram dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .pix_tdata(pix_tdata), .pix_tvalid(pix_tvalid), .pix_tready(pix_tready), .pix_tlast(pix_tlast),
        .hist_bin(hist_bin), .hist_cnt(hist_cnt), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist_last(hist_last)
    );

    threshold2_histogram #(.BIN_W(8), .CNT_W(4)) dut_s (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .pix_tdata(s_tdata), .pix_tvalid(s_tvalid), .pix_tready(s_tready), .pix_tlast(s_tlast),
        .hist_bin(s_bin), .hist_cnt(s_cnt), .hist_valid(s_valid),
        .hist_ready(s_ready), .hist_last(s_last)
    );

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Counts cycles until pix_tready rises, offering junk pixels that must be ignored.
    task automatic wait_ready(input string tag);
        int n = 0;
        pix_tvalid = 1'b1;
        pix_tdata  = 8'h33;
        while (!pix_tready && n < 600) begin
            tick();
            n++;
        end
        pix_tvalid = 1'b0;
        chk(tag, n, 256);
    endtask

    task automatic do_reset;
        ap_rst = 1'b1;
        tick();
        chk("rst_tready", pix_tready, 0);
        chk("rst_hvalid", hist_valid, 0);
        chk("rst_hlast",  hist_last, 0);
        chk("rst_hbin",   hist_bin, 0);
        chk("rst_hcnt",   hist_cnt, 0);
        ap_rst = 1'b0;
        wait_ready("clear_len");
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        pix_tdata  = d;
        pix_tvalid = 1'b1;
        pix_tlast  = last;
        tick();
        pix_tvalid = 1'b0;
        pix_tlast  = 1'b0;
    endtask

    task automatic clr_exp;
        for (int i = 0; i < 256; i++) exp_h[i] = '0;
    endtask

    // mode 0: hist_ready held high; mode 1: hist_ready toggles. abort_at >= 0 pulses reset at that beat.
    task automatic dump(input string tag, input int mode, input int abort_at);
        int beats = 0, cyc = 0, first_wait = -1, bubbles = 0;
        int order_err = 0, last_err = 0, stall_err = 0;
        logic sv, sl, sr;
        logic [7:0] sb;
        logic [19:0] sc;
        for (int i = 0; i < 256; i++) got[i] = 20'hABCDE;
        pix_tvalid = 1'b1;
        pix_tdata  = 8'h44;
        while (beats < 256 && cyc < 3000) begin
            sr = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            hist_ready = sr;
            sv = hist_valid; sb = hist_bin; sc = hist_cnt; sl = hist_last;
            if (abort_at >= 0 && beats == abort_at) begin
                ap_rst = 1'b1;
                tick();
                ap_rst = 1'b0;
                pix_tvalid = 1'b0;
                hist_ready = 1'b0;
                chk({tag, "_rst_hvalid"}, hist_valid, 0);
                chk({tag, "_rst_tready"}, pix_tready, 0);
                return;
            end
            tick();
            cyc++;
            if (first_wait < 0 && hist_valid) first_wait = cyc;
            if (sv && sr) begin
                if (sb != beats[7:0]) order_err++;
                if (sl != (beats == 255)) last_err++;
                got[sb] = sc;
                beats++;
                if (mode == 0 && beats < 256 && !hist_valid) bubbles++;
            end else if (sv && !sr) begin
                if (!hist_valid || hist_bin != sb || hist_cnt != sc || hist_last != sl) stall_err++;
            end
        end
        pix_tvalid = 1'b0;
        hist_ready = 1'b0;
        chk({tag, "_beats"}, beats, 256);
        chk({tag, "_order"}, order_err, 0);
        chk({tag, "_last"}, last_err, 0);
        chk({tag, "_first_lat_ok"}, (first_wait > 0 && first_wait <= 5), 1);
        chk({tag, "_back_to_accum"}, pix_tready, 1);
        if (mode == 0) chk({tag, "_bubbles"}, bubbles, 0);
        else chk({tag, "_stall_stable"}, stall_err, 0);
    endtask

    task automatic cmp(input string tag);
        int mism = 0;
        for (int i = 0; i < 256; i++) if (got[i] !== exp_h[i]) mism++;
        chk(tag, mism, 0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [3:0] sc4;
        logic [7:0] sb4;
        ap_rst = 1'b1;
        pix_tdata = '0; pix_tvalid = 1'b0; pix_tlast = 1'b0; hist_ready = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_ready = 1'b0;

        do_reset();

        // 18 pixels of 0xFF into 4-bit counters: wraps to 2, or saturates at 15.
        chk("s_tready", s_tready, 1);
        for (int i = 0; i < 18; i++) begin
            s_tdata = 8'hFF; s_tvalid = 1'b1; s_tlast = (i == 17);
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_ready = 1'b1;
        n = 0; seen = 1'b0; sc4 = '0; sb4 = '0;
        while (!seen && n < 1000) begin
            if (s_valid && s_last) begin
                seen = 1'b1; sc4 = s_cnt; sb4 = s_bin;
            end
            tick();
            n++;
        end
        s_ready = 1'b0;
        chk("s_last_seen", seen, 1);
        chk("s_last_bin", sb4, 8'hFF);
`ifdef THRESHOLD2_HIST_SAT_EN
        chk("s_bin255_sat", sc4, 15);
`else
        chk("s_bin255_wrap", sc4, 2);
`endif

        // single tlast pixel 0x00
        clr_exp();
        send(8'h00, 1'b1);
        chk("f1_tready_drop", pix_tready, 0);
        exp_h[0] = 1;
        dump("f1", 0, -1);
        cmp("f1_bins");

        // 1000 back-to-back 0x7F
        clr_exp();
        for (int i = 0; i < 999; i++) send(8'h7F, 1'b0);
        send(8'h7F, 1'b1);
        exp_h[8'h7F] = 1000;
        dump("f2", 0, -1);
        chk("f2_bin7f", got[8'h7F], 1000);
        cmp("f2_bins");

        // forwarding pattern, twice (second dump stalled every other cycle)
        clr_exp();
        exp_h[8'h10] = 3;
        exp_h[8'h20] = 2;
        send(8'h10, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b1);
        dump("f3", 0, -1);
        cmp("f3_bins");
        send(8'h10, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b1);
        dump("f4", 1, -1);
        chk("f4_bin10", got[8'h10], 3);
        cmp("f4_bins");

        // A,B,A then idle cycles then A
        clr_exp();
        exp_h[8'h01] = 3;
        exp_h[8'h02] = 1;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        send(8'h01, 1'b1);
        dump("f5", 1, -1);
        cmp("f5_bins");

        // reset at beat 100, full clear, then a one-pixel frame
        send(8'h30, 1'b0); send(8'h30, 1'b0); send(8'h30, 1'b1);
        dump("f6", 0, 100);
        wait_ready("clear_after_rst");
        clr_exp();
        exp_h[8'h05] = 1;
        send(8'h05, 1'b1);
        dump("f7", 0, -1);
        chk("f7_bin30", got[8'h30], 0);
        cmp("f7_bins");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
